// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared definitions for the code lock controller.
//   state_t        controller state encoding
//   LED_*          bit positions within the 5-bit led status output
// The LOCKOUT state exists only when CODE_LOCK_LOCKOUT_EN is defined.
package code_lock_pkg;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_OPEN,
    S_ERROR,
    S_CHANGE_NEW,
    S_CHANGE_CONF
`ifdef CODE_LOCK_LOCKOUT_EN
    , S_LOCKOUT
`endif
  } state_t;

  localparam int unsigned LED_LOCKED  = 0;
  localparam int unsigned LED_OPEN    = 1;
  localparam int unsigned LED_ERROR   = 2;
  localparam int unsigned LED_CHANGE  = 3;
  localparam int unsigned LED_LOCKOUT = 4;

endpackage

// File: rtl/digit_shift_buf.sv
// digit_shift_buf: digit entry buffer for the code lock.
//   clk, rst   clock, asynchronous active-high reset
//   shift      shift din in as the newest digit (ignored when full)
//   clr        empty the buffer (wins over shift)
//   din        digit to shift in
//   digits     buffer contents, newest digit in bits [DIGIT_W-1:0]
//   blank      1 = digit position empty
//   count      number of digits held
//   full       count == DIGITS
module digit_shift_buf
  import code_lock_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shift,
  input  logic                          clr,
  input  logic [DIGIT_W-1:0]            din,
  output logic [DIGITS*DIGIT_W-1:0]     digits,
  output logic [DIGITS-1:0]             blank,
  output logic [$clog2(DIGITS+1)-1:0]   count,
  output logic                          full
);

  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  logic [DIGITS*DIGIT_W-1:0] din_ext;

  always_comb begin
    din_ext                = '0;
    din_ext[DIGIT_W-1:0]   = din;
  end

  assign full = (count == CNT_W'(DIGITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits <= '0;
      blank  <= '1;
      count  <= '0;
    end else if (clr) begin
      digits <= '0;
      blank  <= '1;
      count  <= '0;
    end else if (shift && !full) begin
      digits <= (digits << DIGIT_W) | din_ext;
      // Filled positions grow from bit 0 upward, so shifting the mask
      // clears exactly the lowest blank bit.
      blank  <= blank << 1;
      count  <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: digital code lock with code change and error hold-off.
//   clk, rst    clock, asynchronous active-high reset
//   clear       pulse: empty entry buffer / leave OPEN, ERROR, change mode
//   enter       pulse: shift in switch digit, or submit a full buffer
//   change      pulse: from OPEN start a code change
//   switch      digit value sampled on enter
//   led         [0] locked [1] open [2] error [3] change mode [4] lockout
//   ssd_digits  entry buffer, newest digit in the low bits
//   ssd_blank   1 = digit position empty
//   fail_cnt    consecutive failed attempts
// Optional feature macro: CODE_LOCK_LOCKOUT_EN (lockout after MAX_TRIES
// consecutive failures). Without it, led[4] is 0 and fail_cnt saturates.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int unsigned                 DIGITS      = 4,
  parameter int unsigned                 DIGIT_W     = 4,
  parameter int unsigned                 RADIX       = 10,
  parameter int unsigned                 MAX_TRIES   = 3,
  parameter int unsigned                 ERR_CYC     = 50,
  parameter int unsigned                 LOCKOUT_CYC = 500,
  parameter logic [DIGITS*DIGIT_W-1:0]   RESET_CODE  = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               enter,
  input  logic                               change,
  input  logic [DIGIT_W-1:0]                 switch,
  output logic [4:0]                         led,
  output logic [DIGITS*DIGIT_W-1:0]          ssd_digits,
  output logic [DIGITS-1:0]                  ssd_blank,
  output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt
);

  localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned ERR_W  = $clog2(ERR_CYC + 1);
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
  localparam int unsigned CODE_W = DIGITS * DIGIT_W;

  state_t              state, state_n;
  logic [CODE_W-1:0]   code, code_n;
  logic [CODE_W-1:0]   stage, stage_n;
  logic [ERR_W-1:0]    err_tmr, err_n;
  logic [FAIL_W-1:0]   fail_n;
  logic [4:0]          led_n;

`ifdef CODE_LOCK_LOCKOUT_EN
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYC + 1);
  logic [LOCK_W-1:0]   lock_tmr, lock_n;
`endif

  logic clr_p, ent_p, chg_p;
  logic digit_ok;
  logic buf_shift, buf_clr, buf_full;
  logic [CNT_W-1:0] buf_count;

  // Single pulse per cycle: clear beats enter beats change.
  assign clr_p    = clear;
  assign ent_p    = enter & ~clear;
  assign chg_p    = change & ~clear & ~enter;
  assign digit_ok = (32'(switch) < RADIX);

  digit_shift_buf #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .shift  (buf_shift),
    .clr    (buf_clr),
    .din    (switch),
    .digits (ssd_digits),
    .blank  (ssd_blank),
    .count  (buf_count),
    .full   (buf_full)
  );

  always_comb begin
    state_n   = state;
    code_n    = code;
    stage_n   = stage;
    err_n     = err_tmr;
    fail_n    = fail_cnt;
    buf_shift = 1'b0;
    buf_clr   = 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
    lock_n    = lock_tmr;
`endif
    case (state)
      S_LOCKED: begin
        if (clr_p) begin
          buf_clr = 1'b1;
        end else if (ent_p) begin
          if (buf_full) begin
            buf_clr = 1'b1;
            if (ssd_digits == code) begin
              state_n = S_OPEN;
              fail_n  = '0;
            end else begin
              fail_n = (fail_cnt == FAIL_W'(MAX_TRIES)) ? fail_cnt
                                                        : fail_cnt + FAIL_W'(1);
`ifdef CODE_LOCK_LOCKOUT_EN
              if (fail_n == FAIL_W'(MAX_TRIES)) begin
                state_n = S_LOCKOUT;
                lock_n  = LOCK_W'(LOCKOUT_CYC - 1);
              end else begin
                state_n = S_ERROR;
                err_n   = ERR_W'(ERR_CYC - 1);
              end
`else
              state_n = S_ERROR;
              err_n   = ERR_W'(ERR_CYC - 1);
`endif
            end
          end else if (digit_ok) begin
            buf_shift = 1'b1;
          end
        end
      end
      S_ERROR: begin
        // Timer is loaded with ERR_CYC-1 so the indication lasts ERR_CYC cycles.
        if (clr_p || err_tmr == '0) begin
          state_n = S_LOCKED;
          err_n   = '0;
        end else begin
          err_n = err_tmr - ERR_W'(1);
        end
      end
      S_OPEN: begin
        if (clr_p) begin
          state_n = S_LOCKED;
        end else if (chg_p) begin
          state_n = S_CHANGE_NEW;
          buf_clr = 1'b1;
        end
      end
      S_CHANGE_NEW, S_CHANGE_CONF: begin
        if (clr_p) begin
          buf_clr = 1'b1;
          if (buf_count == '0) begin
            state_n = S_OPEN;
            stage_n = '0;
          end
        end else if (ent_p) begin
          if (buf_full) begin
            buf_clr = 1'b1;
            if (state == S_CHANGE_NEW) begin
              stage_n = ssd_digits;
              state_n = S_CHANGE_CONF;
            end else begin
              if (ssd_digits == stage) code_n = stage;
              stage_n = '0;
              state_n = S_OPEN;
            end
          end else if (digit_ok) begin
            buf_shift = 1'b1;
          end
        end
      end
`ifdef CODE_LOCK_LOCKOUT_EN
      S_LOCKOUT: begin
        if (lock_tmr == '0) begin
          state_n = S_LOCKED;
          fail_n  = '0;
        end else begin
          lock_n = lock_tmr - LOCK_W'(1);
        end
      end
`endif
      default: state_n = S_LOCKED;
    endcase
  end

  // led is decoded from the next state so it registers alongside state.
  always_comb begin
    led_n = '0;
    case (state_n)
      S_LOCKED:                    led_n[LED_LOCKED] = 1'b1;
      S_OPEN:                      led_n[LED_OPEN]   = 1'b1;
      S_ERROR:                     led_n[LED_ERROR]  = 1'b1;
      S_CHANGE_NEW, S_CHANGE_CONF: led_n[LED_CHANGE] = 1'b1;
`ifdef CODE_LOCK_LOCKOUT_EN
      S_LOCKOUT:                   led_n[LED_LOCKOUT] = 1'b1;
`endif
      default:                     led_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_LOCKED;
      led      <= 5'b00001;
      code     <= RESET_CODE;
      stage    <= '0;
      err_tmr  <= '0;
      fail_cnt <= '0;
    end else begin
      state    <= state_n;
      led      <= led_n;
      code     <= code_n;
      stage    <= stage_n;
      err_tmr  <= err_n;
      fail_cnt <= fail_n;
    end
  end

`ifdef CODE_LOCK_LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_tmr <= '0;
    else     lock_tmr <= lock_n;
  end
`endif

endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: directed self-checking bench for code_lock_ctrl
// with default parameters (4 decimal digits, 3 tries, 50/500 cycle timers).
module tb_code_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        enter = 1'b0;
  logic        change = 1'b0;
  logic [3:0]  switch = 4'd0;
  logic [4:0]  led;
  logic [15:0] ssd_digits;
  logic [3:0]  ssd_blank;
  logic [1:0]  fail_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  code_lock_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .enter      (enter),
    .change     (change),
    .switch     (switch),
    .led        (led),
    .ssd_digits (ssd_digits),
    .ssd_blank  (ssd_blank),
    .fail_cnt   (fail_cnt)
  );

  // Stimulus helpers: each returns 1ns after the edge that sampled the pulse.
  task automatic press_enter(input logic [3:0] d);
    switch = d; enter = 1'b1;
    @(posedge clk); #1;
    enter = 1'b0;
  endtask

  task automatic press_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic press_change();
    change = 1'b1;
    @(posedge clk); #1;
    change = 1'b0;
  endtask

  task automatic key_digits(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] d;
      d = c[i*4 +: 4];
      press_enter(d);
    end
  endtask

  task automatic enter_code(input logic [15:0] c);
    key_digits(c);
    press_enter(4'd0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (led !== 5'b00001) begin errors++; $display("FAIL reset_led got=%b want=%b", led, 5'b00001); end
    checks++; if (ssd_digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got=%h want=%h", ssd_digits, 16'h0000); end
    checks++; if (ssd_blank !== 4'b1111) begin errors++; $display("FAIL reset_blank got=%b want=%b", ssd_blank, 4'b1111); end
    checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL reset_fail got=%0d want=0", fail_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (led !== 5'b00001) begin errors++; $display("FAIL idle_led got=%b want=%b", led, 5'b00001); end
  endtask

  task automatic test_open();
    key_digits(16'h0000);
    checks++; if (ssd_blank !== 4'b0000) begin errors++; $display("FAIL open_full_blank got=%b want=0000", ssd_blank); end
    press_enter(4'd0);
    checks++; if (led !== 5'b00010) begin errors++; $display("FAIL open_led got=%b want=00010", led); end
    checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL open_fail got=%0d want=0", fail_cnt); end
    checks++; if (ssd_blank !== 4'b1111) begin errors++; $display("FAIL open_blank got=%b want=1111", ssd_blank); end
    press_clear();
    checks++; if (led !== 5'b00001) begin errors++; $display("FAIL open_clear_led got=%b want=00001", led); end
  endtask

  task automatic test_error();
    bit held_ok;
    key_digits(16'h1234);
    checks++; if (ssd_digits !== 16'h1234) begin errors++; $display("FAIL err_digits got=%h want=1234", ssd_digits); end
    press_enter(4'd0);
    checks++; if (led !== 5'b00100) begin errors++; $display("FAIL err_led got=%b want=00100", led); end
    checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL err_fail got=%0d want=1", fail_cnt); end
    held_ok = 1'b1;
    for (int i = 1; i < 50; i++) begin
      @(posedge clk); #1;
      if (led !== 5'b00100) held_ok = 1'b0;
    end
    checks++; if (!held_ok) begin errors++; $display("FAIL err_hold led left 00100 before cycle 50 now=%b", led); end
    @(posedge clk); #1;
    checks++; if (led !== 5'b00001) begin errors++; $display("FAIL err_expire got=%b want=00001", led); end
    enter_code(16'h1234);
    checks++; if (fail_cnt !== 2'd2) begin errors++; $display("FAIL err_fail2 got=%0d want=2", fail_cnt); end
    press_enter(4'd5);
    checks++; if (ssd_blank !== 4'b1111 || led !== 5'b00100) begin errors++; $display("FAIL err_enter_ignored blank=%b led=%b want 1111/00100", ssd_blank, led); end
    press_clear();
    checks++; if (led !== 5'b00001) begin errors++; $display("FAIL err_clear got=%b want=00001", led); end
    enter_code(16'h0000);
    checks++; if (led !== 5'b00010 || fail_cnt !== 2'd0) begin errors++; $display("FAIL err_recover led=%b fail=%0d want 00010/0", led, fail_cnt); end
  endtask

  task automatic test_change();
    press_change();
    checks++; if (led !== 5'b01000 || ssd_blank !== 4'b1111) begin errors++; $display("FAIL chg_enter led=%b blank=%b want 01000/1111", led, ssd_blank); end
    enter_code(16'h5678);
    checks++; if (led !== 5'b01000 || ssd_blank !== 4'b1111) begin errors++; $display("FAIL chg_new led=%b blank=%b want 01000/1111", led, ssd_blank); end
    enter_code(16'h5678);
    checks++; if (led !== 5'b00010) begin errors++; $display("FAIL chg_conf got=%b want=00010", led); end
    press_clear();
    enter_code(16'h5678);
    checks++; if (led !== 5'b00010) begin errors++; $display("FAIL chg_newcode got=%b want=00010", led); end
    press_change();
    enter_code(16'h1111);
    enter_code(16'h1112);
    checks++; if (led !== 5'b00010) begin errors++; $display("FAIL chg_mismatch got=%b want=00010", led); end
    press_clear();
    enter_code(16'h5678);
    checks++; if (led !== 5'b00010) begin errors++; $display("FAIL chg_unchanged got=%b want=00010", led); end
    press_change();
    press_enter(4'd1);
    press_enter(4'd2);
    press_clear();
    checks++; if (led !== 5'b01000 || ssd_blank !== 4'b1111) begin errors++; $display("FAIL chg_clear_buf led=%b blank=%b want 01000/1111", led, ssd_blank); end
    press_clear();
    checks++; if (led !== 5'b00010) begin errors++; $display("FAIL chg_abort got=%b want=00010", led); end
    press_clear();
    press_change();
    checks++; if (led !== 5'b00001) begin errors++; $display("FAIL chg_locked_ignored got=%b want=00001", led); end
  endtask

  task automatic test_boundary();
    press_enter(4'd12);
    checks++; if (ssd_blank !== 4'b1111 || ssd_digits !== 16'h0000) begin errors++; $display("FAIL bnd_radix blank=%b digits=%h want 1111/0000", ssd_blank, ssd_digits); end
    press_enter(4'd9);
    press_enter(4'd3);
    checks++; if (ssd_digits !== 16'h0093 || ssd_blank !== 4'b1100) begin errors++; $display("FAIL bnd_two digits=%h blank=%b want 0093/1100", ssd_digits, ssd_blank); end
    switch = 4'd4; clear = 1'b1; enter = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; enter = 1'b0;
    checks++; if (ssd_digits !== 16'h0000 || ssd_blank !== 4'b1111) begin errors++; $display("FAIL bnd_clr_ent digits=%h blank=%b want 0000/1111", ssd_digits, ssd_blank); end
    enter_code(16'h5678);
    enter = 1'b1; change = 1'b1;
    @(posedge clk); #1;
    enter = 1'b0; change = 1'b0;
    checks++; if (led !== 5'b00010) begin errors++; $display("FAIL bnd_ent_chg got=%b want=00010", led); end
    press_clear();
  endtask

`ifdef CODE_LOCK_LOCKOUT_EN
  task automatic test_lockout();
    enter_code(16'h1234);
    press_clear();
    enter_code(16'h1234);
    press_clear();
    enter_code(16'h1234);
    checks++; if (led !== 5'b10000 || fail_cnt !== 2'd3) begin errors++; $display("FAIL lck_enter led=%b fail=%0d want 10000/3", led, fail_cnt); end
    enter_code(16'h5678);
    checks++; if (led !== 5'b10000 || ssd_blank !== 4'b1111) begin errors++; $display("FAIL lck_ignore led=%b blank=%b want 10000/1111", led, ssd_blank); end
    repeat (494) @(posedge clk);
    #1;
    checks++; if (led !== 5'b10000) begin errors++; $display("FAIL lck_hold got=%b want=10000", led); end
    @(posedge clk); #1;
    checks++; if (led !== 5'b00001 || fail_cnt !== 2'd0) begin errors++; $display("FAIL lck_exit led=%b fail=%0d want 00001/0", led, fail_cnt); end
  endtask
`else
  task automatic test_saturate();
    for (int i = 0; i < 4; i++) begin
      enter_code(16'h1234);
      if (i < 3) press_clear();
    end
    checks++; if (fail_cnt !== 2'd3) begin errors++; $display("FAIL sat_fail got=%0d want=3", fail_cnt); end
    checks++; if (led !== 5'b00100) begin errors++; $display("FAIL sat_led got=%b want=00100", led); end
    press_clear();
  endtask
`endif

  task automatic test_rst_mid();
    enter_code(16'h5678);
    press_change();
    enter_code(16'h1111);
    press_enter(4'd1);
    press_enter(4'd1);
    checks++; if (led !== 5'b01000 || ssd_blank !== 4'b1100) begin errors++; $display("FAIL rst_pre led=%b blank=%b want 01000/1100", led, ssd_blank); end
    #2 rst = 1'b1;
    #1;
    checks++; if (led !== 5'b00001 || ssd_blank !== 4'b1111 || ssd_digits !== 16'h0000) begin errors++; $display("FAIL rst_async led=%b blank=%b digits=%h", led, ssd_blank, ssd_digits); end
    @(posedge clk); #1;
    rst = 1'b0;
    enter_code(16'h0000);
    checks++; if (led !== 5'b00010 || fail_cnt !== 2'd0) begin errors++; $display("FAIL rst_code led=%b fail=%0d want 00010/0", led, fail_cnt); end
  endtask

  initial begin
    test_reset();
    test_open();
    test_error();
    test_change();
    test_boundary();
`ifdef CODE_LOCK_LOCKOUT_EN
    test_lockout();
`else
    test_saturate();
`endif
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/code_lock_ctrl.md
CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

Interface
REQ-001 Parameter DIGITS, 4, code length in digits (1..8).
REQ-002 Parameter DIGIT_W, 4, bits per digit.
REQ-003 Parameter RADIX, 10, legal digit values 0..RADIX-1 (RADIX <= 2**DIGIT_W).
REQ-004 Parameter MAX_TRIES, 3, consecutive failures before lockout.
REQ-005 Parameter ERR_CYC, 50, clk cycles the ERROR indication is held.
REQ-006 Parameter LOCKOUT_CYC, 500, clk cycles of lockout.
REQ-007 Parameter RESET_CODE, all zeros, DIGITS*DIGIT_W stored code after reset.
REQ-008 Port clk, in, 1, single clock; all logic on its rising edge.
REQ-009 Port rst, in, 1, asynchronous active-high reset.
REQ-010 Port clear, in, 1, debounced single-cycle pulse.
REQ-011 Port enter, in, 1, debounced single-cycle pulse.
REQ-012 Port change, in, 1, debounced single-cycle pulse.
REQ-013 Port switch, in, DIGIT_W, digit value sampled on enter.
REQ-014 Port led, out, 5, status: [0] locked, [1] open, [2] error, [3] change mode, [4] lockout.
REQ-015 Port ssd_digits, out, DIGITS*DIGIT_W, entry buffer; newest digit in bits [DIGIT_W-1:0].
REQ-016 Port ssd_blank, out, DIGITS, 1 = digit position empty.
REQ-017 Port fail_cnt, out, clog2(MAX_TRIES+1), consecutive failed attempts.

Function
REQ-018 States LOCKED, OPEN, ERROR, CHANGE_NEW, CHANGE_CONF, LOCKOUT; all outputs registered, reacting one cycle after the input pulse.
REQ-019 Same-cycle pulse priority clear > enter > change; lower-priority pulses that cycle are dropped.
REQ-020 Digit entry (LOCKED, CHANGE_NEW, CHANGE_CONF): enter with buffer not full and switch < RADIX shifts switch in, count+1, lowest blank bit cleared.
REQ-021 enter with switch >= RADIX: no effect.
REQ-022 clear in any entry state empties buffer (digits 0, blank all 1, count 0).
REQ-023 LOCKED, buffer full, enter: match stored code -> OPEN, fail_cnt 0; mismatch -> ERROR, fail_cnt+1 (saturating at MAX_TRIES); buffer emptied either way.
REQ-024 ERROR: held ERR_CYC cycles, then LOCKED; clear exits to LOCKED immediately; enter/change ignored.
REQ-025 OPEN: clear -> LOCKED; change -> CHANGE_NEW with empty buffer; enter ignored.
REQ-026 CHANGE_NEW, buffer full, enter: buffer copied to staging register, -> CHANGE_CONF, buffer emptied.
REQ-027 CHANGE_CONF, buffer full, enter: match staging -> stored code updated, OPEN; mismatch -> OPEN, stored code unchanged.
REQ-028 clear with empty buffer in CHANGE_NEW/CHANGE_CONF -> OPEN, staging discarded.
REQ-029 change outside OPEN ignored.
REQ-030 Timers are down-counters sized to their cycle parameter; wrap never occurs.

Reset
REQ-031 On rst: state LOCKED, led 5'b00001, ssd_digits 0, ssd_blank all 1, fail_cnt 0, stored code RESET_CODE, staging 0, timers 0.
REQ-032 rst asserted mid-entry, mid-change or mid-lockout aborts the operation and applies REQ-031.

Configuration
REQ-033 Macro CODE_LOCK_LOCKOUT_EN defined: entering ERROR with fail_cnt reaching MAX_TRIES goes to LOCKOUT instead; LOCKOUT ignores all pulses for LOCKOUT_CYC cycles, then LOCKED with fail_cnt 0.
REQ-034 Macro undefined: LOCKOUT state, its timer and led[4] logic absent; led[4] tied 0; fail_cnt saturates.

Structure
REQ-035 Package code_lock_pkg holds state enum and LED bit index constants.
REQ-036 Sub-module digit_shift_buf holds shift register, count, blank mask, full flag; parameters DIGITS, DIGIT_W.

Verification
REQ-037 Reset, enter 0,0,0,0 then enter -> OPEN, led 00010, fail_cnt 0.
REQ-038 Enter 1,2,3,4 then enter -> ERROR for 50 cycles, fail_cnt 1, then led 00001.
REQ-039 OPEN, change, 5,6,7,8, enter, 5,6,7,8, enter -> OPEN; clear; 5,6,7,8, enter -> OPEN; confirm 5,6,7,9 instead -> code unchanged.
REQ-040 switch=12 with enter -> ssd_blank stays 4'b1111; clear and enter same cycle after two digits -> buffer empty, no digit added.
REQ-041 With CODE_LOCK_LOCKOUT_EN: three wrong codes -> led 10000 for 500 cycles, correct code ignored during it, then LOCKED, fail_cnt 0.
REQ-042 rst pulsed during CHANGE_CONF -> stored code equals RESET_CODE, state LOCKED.
